// File: rtl/strobe_period_monitor.sv
// strobe_period_monitor: measures the spacing of a periodic enable strobe,
// checks it against an expected period and tracks lock, fault and errors.
module strobe_period_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 200,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             strobe,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault,
    output logic [7:0]       err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_TRACK  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W:0]   LO_V   = (CNT_W+1)'(EXP_PERIOD - TOL);
    localparam logic [CNT_W:0]   HI_V   = (CNT_W+1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] HI_CNT = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [GC_W-1:0]  GC_TOP = GC_W'(LOCK_CNT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [GC_W-1:0]   r_good;
    logic [CNT_W-1:0]  r_period;
    logic              r_pv;
    logic              r_locked;
    logic              r_fault;
    logic [7:0]        r_err;

    logic [CNT_W:0]    w_interval;
    logic              w_good;
    logic              w_timeout;
    logic [7:0]        w_err_next;

    // Interval is one more than the count since the counter clears on the strobe
    assign w_interval = {1'b0, r_cnt} + 1'b1;
    assign w_good     = (w_interval >= LO_V) && (w_interval <= HI_V);
    assign w_timeout  = !strobe && (r_cnt == HI_CNT);
    assign w_err_next = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_good   <= '0;
            r_period <= '0;
            r_pv     <= 1'b0;
            r_locked <= 1'b0;
            r_fault  <= 1'b0;
            r_err    <= 8'd0;
        end else begin
            r_pv <= 1'b0;
            if (!en) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_good   <= '0;
                r_locked <= 1'b0;
                r_fault  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_ARM;
                        r_cnt   <= '0;
                    end
                    S_ARM: begin
                        if (strobe) begin
                            r_state <= S_TRACK;
                            r_cnt   <= '0;
                            r_good  <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_TRACK, S_LOCKED: begin
                        if (strobe) begin
                            r_cnt    <= '0;
                            r_period <= w_interval[CNT_W-1:0];
                            r_pv     <= 1'b1;
                            if (w_good) begin
                                if (r_state == S_TRACK) begin
                                    if (r_good == GC_TOP) begin
                                        r_state  <= S_LOCKED;
                                        r_locked <= 1'b1;
                                        r_good   <= '0;
                                    end else begin
                                        r_good <= r_good + 1'b1;
                                    end
                                end
                            end else begin
                                r_state  <= S_TRACK;
                                r_locked <= 1'b0;
                                r_good   <= '0;
                                r_err    <= w_err_next;
                                if (r_state == S_LOCKED)
                                    r_fault <= 1'b1;
                            end
                        end else if (w_timeout) begin
                            r_state  <= S_ARM;
                            r_locked <= 1'b0;
                            r_cnt    <= '0;
                            r_good   <= '0;
                            r_err    <= w_err_next;
                            if (r_state == S_LOCKED)
                                r_fault <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_pv;
    assign locked       = r_locked;
    assign fault        = r_fault;
    assign err_count    = r_err;
    assign state        = r_state;

endmodule

// File: tb/tb_strobe_period_monitor.sv
// tb_strobe_period_monitor: table vectors, hand sequences and random
// stimulus checked against a timestamp-based reference model.
module tb_strobe_period_monitor;

    localparam int CNT_W = 8;
    localparam int EXP   = 200;
    localparam int TOLV  = 2;
    localparam int LCK   = 4;
    localparam int LO    = EXP - TOLV;
    localparam int HI    = EXP + TOLV;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             strobe;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             fault;
    logic [7:0]       err_count;
    logic [1:0]       state;

    strobe_period_monitor #(
        .CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOLV), .LOCK_CNT(LCK)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .strobe(strobe),
        .period(period), .period_valid(period_valid), .locked(locked),
        .fault(fault), .err_count(err_count), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a mode plus the timestamp of the last reference strobe
    int m_st, m_last, m_t, m_good, m_per, m_err;
    bit m_pv, m_flt;

    typedef struct {
        int       gap;
        logic [1:0] st;
        bit       pv;
        int       per;
        bit       lk;
        bit       flt;
        int       err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_good = 0; m_per = 0; m_err = 0; m_pv = 0; m_flt = 0;
        m_last = 0;
    endtask

    task automatic err_event();
        if (m_err < 255) m_err++;
        if (m_st == 3) m_flt = 1;
    endtask

    task automatic model_step(input bit e, input bit s);
        int iv;
        m_pv = 0;
        if (!e) begin
            m_st = 0; m_good = 0; m_flt = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (s) begin m_st = 2; m_last = m_t; m_good = 0; end
        end else begin
            iv = m_t - m_last;
            if (s) begin
                m_per = iv % 256;
                m_pv = 1;
                m_last = m_t;
                if (iv >= LO && iv <= HI) begin
                    if (m_st == 2) begin
                        m_good++;
                        if (m_good == LCK) begin m_st = 3; m_good = 0; end
                    end
                end else begin
                    err_event();
                    m_st = 2; m_good = 0;
                end
            end else if (iv == HI + 1) begin
                err_event();
                m_st = 1; m_good = 0;
            end
        end
        m_t++;
    endtask

    function automatic int pack_dut();
        return {11'd0, state, period, period_valid, locked, fault, err_count};
    endfunction

    function automatic int pack_model();
        logic [1:0] s2;
        logic [7:0] p8, e8;
        s2 = 2'(m_st); p8 = 8'(m_per); e8 = 8'(m_err);
        return {11'd0, s2, p8, m_pv, (m_st == 3), m_flt, e8};
    endfunction

    task automatic cycle(input bit e, input bit s);
        en = e; strobe = s;
        @(posedge clk);
        model_step(e, s);
        #1;
        chk("model", pack_dut(), pack_model());
    endtask

    task automatic apply_strobe(input int gap);
        for (int i = 0; i < gap - 1; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk({tag, "_state"}, state, v.st);
        chk({tag, "_pv"}, period_valid, v.pv);
        chk({tag, "_period"}, period, v.per);
        chk({tag, "_locked"}, locked, v.lk);
        chk({tag, "_fault"}, fault, v.flt);
        chk({tag, "_err"}, err_count, v.err);
    endtask

    initial begin
        bit saw_lock;
        int r, g;
        tbl.push_back('{5,   2'd2, 1'b0, 0,   1'b0, 1'b0, 0});
        tbl.push_back('{200, 2'd2, 1'b1, 200, 1'b0, 1'b0, 0});
        tbl.push_back('{200, 2'd2, 1'b1, 200, 1'b0, 1'b0, 0});
        tbl.push_back('{200, 2'd2, 1'b1, 200, 1'b0, 1'b0, 0});
        tbl.push_back('{200, 2'd3, 1'b1, 200, 1'b1, 1'b0, 0});
        tbl.push_back('{200, 2'd3, 1'b1, 200, 1'b1, 1'b0, 0});
        tbl.push_back('{198, 2'd3, 1'b1, 198, 1'b1, 1'b0, 0});
        tbl.push_back('{202, 2'd3, 1'b1, 202, 1'b1, 1'b0, 0});
        tbl.push_back('{203, 2'd2, 1'b1, 203, 1'b0, 1'b1, 1});
        tbl.push_back('{203, 2'd2, 1'b1, 203, 1'b0, 1'b1, 2});
        tbl.push_back('{200, 2'd2, 1'b1, 200, 1'b0, 1'b1, 2});
        tbl.push_back('{200, 2'd2, 1'b1, 200, 1'b0, 1'b1, 2});
        tbl.push_back('{200, 2'd2, 1'b1, 200, 1'b0, 1'b1, 2});
        tbl.push_back('{200, 2'd3, 1'b1, 200, 1'b1, 1'b1, 2});

        reset = 1'b1; en = 1'b0; strobe = 1'b0;
        m_t = 0;
        model_reset();
        #2;
        chk("rst_outputs", pack_dut(), 0);
        #10 reset = 1'b0;

        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk("arm_state", state, 1);

        foreach (tbl[i]) begin
            apply_strobe(tbl[i].gap);
            chk_vec($sformatf("vec%0d", i), tbl[i]);
        end

        for (int i = 0; i < 202; i++) cycle(1'b1, 1'b0);
        chk("pre_timeout_state", state, 3);
        chk("pre_timeout_err", err_count, 2);
        cycle(1'b1, 1'b0);
        chk_vec("timeout", '{0, 2'd1, 1'b0, 200, 1'b0, 1'b1, 3});
        apply_strobe(7);
        chk_vec("rearm", '{0, 2'd2, 1'b0, 200, 1'b0, 1'b1, 3});
        for (int i = 0; i < 4; i++) apply_strobe(200);
        chk_vec("relock", '{0, 2'd3, 1'b1, 200, 1'b1, 1'b1, 3});

        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'(i % 2));
            chk_vec($sformatf("en_off%0d", i), '{0, 2'd0, 1'b0, 200, 1'b0, 1'b0, 3});
        end

        #2 reset = 1'b1;
        #1;
        chk("async_rst", pack_dut(), 0);
        #1 reset = 1'b0;
        model_reset();

        cycle(1'b1, 1'b0);
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 19);
            if (r == 0) g = $urandom_range(1, 3);
            else if (r == 1) g = $urandom_range(204, 230);
            else if (r == 2) begin
                for (int i = 0; i < int'($urandom_range(1, 4)); i++)
                    cycle(1'b0, 1'($urandom_range(0, 1)));
                g = $urandom_range(1, 10);
            end else g = $urandom_range(195, 206);
            apply_strobe(g);
        end

        #2 reset = 1'b1;
        #2 reset = 1'b0;
        model_reset();
        saw_lock = 0;
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            apply_strobe(50);
            if (locked) saw_lock = 1;
        end
        chk("sat_err", err_count, 255);
        chk("sat_state", state, 2);
        chk("sat_nolock", saw_lock, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
